// File: rtl/shade_pixel.sv
// Lambert pixel shader: N.L dot product, clamp + ambient, per-channel scale, FWFT output FIFO.
// Vectors are packed [2:0][31:0] with [0]=x, [1]=y, [2]=z. Define SHADE_AMBIENT_EN to add the ambient term.

module shade_chan (
  input  logic [7:0]  ch,
  input  logic [31:0] intensity,
  output logic [7:0]  out
);
  logic [15:0] scaled;
  assign scaled = 16'((40'(ch) * 40'(intensity)) >> 24);
  assign out    = (scaled > 16'd255) ? 8'hFF : scaled[7:0];
endmodule

module shade_pixel #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] FP_ONE     = 32'h01000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_in,
  input  logic                          hit_in,
  input  logic [2:0][31:0]              surfaceNormal,
  input  logic [2:0][31:0]              surfaceLightVector,
  input  logic [23:0]                   base_color,
  input  logic [23:0]                   bg_color,
  input  logic [31:0]                   ambient,
  output logic                          pixel_valid,
  input  logic                          pixel_ready,
  output logic [23:0]                   pixel_rgb,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [3:1] vld_pipe;

  // stage 1: dot product
  logic signed [63:0] prod [3];
  logic signed [31:0] d_next;
  for (genvar i = 0; i < 3; i++) begin : g_dot
    assign prod[i] = (64'($signed(surfaceNormal[i])) * 64'($signed(surfaceLightVector[i]))) >>> 24;
  end
  assign d_next = 32'(prod[0] + prod[1] + prod[2]);

  logic signed [31:0] s1_d;
  logic               s1_hit;
  logic [2:0][7:0]    s1_base;
  logic [23:0]        s1_bg;

  // stage 2: clamp and intensity
  logic [31:0] diffuse, intensity;
  logic [32:0] isum;
  always_comb begin
    diffuse = s1_d;
    if (s1_d < 0)                     diffuse = '0;
    else if (s1_d > $signed(FP_ONE))  diffuse = FP_ONE;
  end

`ifdef SHADE_AMBIENT_EN
  logic [31:0] amb_eff;
  assign amb_eff = ambient[31] ? '0 : ambient;
  assign isum    = {1'b0, amb_eff} + {1'b0, diffuse};
`else
  logic unused_ambient;
  assign unused_ambient = ^ambient;
  assign isum           = {1'b0, diffuse};
`endif
  assign intensity = (isum > {1'b0, FP_ONE}) ? FP_ONE : isum[31:0];

  logic [31:0]     s2_int;
  logic            s2_hit;
  logic [2:0][7:0] s2_base;
  logic [23:0]     s2_bg;

  // stage 3: per-channel scale
  logic [2:0][7:0] lit;
  for (genvar c = 0; c < 3; c++) begin : g_chan
    shade_chan u_chan (.ch(s2_base[c]), .intensity(s2_int), .out(lit[c]));
  end

  logic [23:0] s3_rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_d     <= '0;
      s1_hit   <= 1'b0;
      s1_base  <= '0;
      s1_bg    <= '0;
      s2_int   <= '0;
      s2_hit   <= 1'b0;
      s2_base  <= '0;
      s2_bg    <= '0;
      s3_rgb   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[2:1], valid_in};
      if (valid_in) begin
        s1_d    <= d_next;
        s1_hit  <= hit_in;
        s1_base <= base_color;
        s1_bg   <= bg_color;
      end
      if (vld_pipe[1]) begin
        s2_int  <= intensity;
        s2_hit  <= s1_hit;
        s2_base <= s1_base;
        s2_bg   <= s1_bg;
      end
      if (vld_pipe[2]) s3_rgb <= s2_hit ? lit : s2_bg;
    end
  end

  // output FIFO; pixel_rgb is a registered copy of the head so it holds when empty
  logic [FIFO_DEPTH-1:0][23:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] cnt_next;
  logic [23:0]   head_next;
  logic          push, pop, full, push_ok, drop;

  assign pixel_valid = (fifo_count != '0);
  assign push        = vld_pipe[3];
  assign pop         = pixel_valid & pixel_ready;
  assign full        = (fifo_count == CW'(FIFO_DEPTH));
  assign push_ok     = push & (~full | pop);
  assign drop        = push & full & ~pop;

  always_comb begin
    rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
    cnt_next  = fifo_count + CW'(push_ok) - CW'(pop);
    head_next = pixel_rgb;
    // when the pushed pixel becomes the head it is not in mem yet, so bypass it
    if (cnt_next != '0)
      head_next = (fifo_count == CW'(pop)) ? s3_rgb : mem[rd_next];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      pixel_rgb  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= s3_rgb;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_next;
      fifo_count <= cnt_next;
      pixel_rgb  <= head_next;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_shade_pixel.sv
// Bench for shade_pixel: vector table through a scoreboard plus FIFO, overflow and reset sequences.
module tb_shade_pixel;
  localparam int DEPTH = 4;
  localparam logic [31:0] ONE  = 32'h01000000;
  localparam logic [31:0] HALF = 32'h00800000;
  localparam logic [31:0] NEG  = 32'hFF000000;
  localparam logic [31:0] TWO  = 32'h02000000;
  localparam logic [31:0] Z    = 32'h0;

  logic clk = 0, rst = 1, valid_in = 0, hit_in = 0, pixel_ready = 0, clear_overflow = 0;
  logic [2:0][31:0] nrm = '0, lgt = '0;
  logic [23:0] base_color = '0, bg_color = '0, pixel_rgb;
  logic [31:0] ambient = '0;
  logic pixel_valid, overflow;
  logic [$clog2(DEPTH):0] fifo_count;

  int tests = 0, fails = 0;
  logic [23:0] q[$];

  typedef struct {
    logic hit; logic [2:0][31:0] n; logic [2:0][31:0] l;
    logic [23:0] base; logic [23:0] bg; logic [31:0] amb; logic [23:0] exp;
  } vec_t;
  vec_t tbl[10];

  shade_pixel #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .hit_in(hit_in),
    .surfaceNormal(nrm), .surfaceLightVector(lgt),
    .base_color(base_color), .bg_color(bg_color), .ambient(ambient),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_rgb(pixel_rgb),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every accepted pixel must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && pixel_valid && pixel_ready) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pixel: got %h expected none", pixel_rgb);
      end else begin
        check("pixel", {8'h0, pixel_rgb}, {8'h0, q.pop_front()});
      end
    end
  end

  function automatic vec_t px(input logic [23:0] base);
    vec_t v;
    v.hit = 1; v.n = {Z, Z, ONE}; v.l = {Z, Z, ONE};
    v.base = base; v.bg = 24'h0; v.amb = 0; v.exp = base;
    return v;
  endfunction

  task automatic send(input vec_t v, input bit expect_out);
    @(negedge clk);
    valid_in = 1; hit_in = v.hit; nrm = v.n; lgt = v.l;
    base_color = v.base; bg_color = v.bg; ambient = v.amb;
    if (expect_out) q.push_back(v.exp);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", q.size(), 0);
  endtask

  initial begin
    tbl[0] = '{1, {Z, ONE, Z},    {Z, ONE, Z},    24'h80FF40, 24'h0, 0, 24'h80FF40};
`ifdef SHADE_AMBIENT_EN
    tbl[1] = '{1, {Z, Z, ONE},    {Z, Z, NEG},    24'h80FF40, 24'h0, 32'h00400000, 24'h203F10};
    tbl[8] = '{1, {Z, Z, HALF},   {Z, Z, ONE},    24'h406080, 24'h0, 32'h00C00000, 24'h406080};
`else
    tbl[1] = '{1, {Z, Z, ONE},    {Z, Z, NEG},    24'h80FF40, 24'h0, 32'h00400000, 24'h000000};
    tbl[8] = '{1, {Z, Z, HALF},   {Z, Z, ONE},    24'h406080, 24'h0, 32'h00C00000, 24'h203040};
`endif
    tbl[2] = '{0, {Z, Z, ONE},    {Z, ONE, Z},    24'hFFFFFF, 24'h1020A0, 0, 24'h1020A0};
    tbl[3] = '{1, {Z, Z, HALF},   {Z, Z, ONE},    24'h80FF40, 24'h0, 0, 24'h407F20};
    tbl[4] = '{1, {Z, Z, TWO},    {Z, Z, ONE},    24'h123456, 24'h0, 0, 24'h123456};
    tbl[5] = '{1, {Z, HALF, HALF}, {Z, HALF, HALF}, 24'hFFFFFF, 24'h0, 0, 24'h7F7F7F};
    tbl[6] = '{1, {Z, Z, NEG},    {Z, Z, NEG},    24'h010203, 24'h0, 0, 24'h010203};
    tbl[7] = '{1, {Z, HALF, HALF}, {Z, HALF, HALF}, 24'hFFFFFF, 24'h0, 32'hFF000000, 24'h7F7F7F};
    tbl[9] = '{1, {HALF, Z, Z},   {NEG, Z, Z},    24'hFFFFFF, 24'h0, 0, 24'h000000};

    #1 rst = 0;
    #1;
    check("rst_valid", pixel_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rgb", pixel_rgb, 0);
    @(negedge clk); @(negedge clk);
    rst = 1; pixel_ready = 1;

    // latency of a single pixel into an empty FIFO
    send(tbl[0], 1); idle();
    check("lat_c1", pixel_valid, 0);
    @(negedge clk); check("lat_c2", pixel_valid, 0);
    @(negedge clk); check("lat_c3", pixel_valid, 0);
    @(negedge clk); check("lat_c4", pixel_valid, 1);
    check("lat_rgb", pixel_rgb, 24'h80FF40);
    drain(20);

    for (int i = 0; i < 10; i++) send(tbl[i], 1);
    idle();
    drain(40);
    check("table_overflow", overflow, 0);

    // five pixels into a stalled FIFO: the fifth is dropped
    pixel_ready = 0;
    for (int i = 0; i < 5; i++) send(px(24'hA00000 + 24'(i)), i < 4);
    idle();
    repeat (5) @(negedge clk);
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", pixel_rgb, 24'hA00000);
    pixel_ready = 1;
    drain(20);
    @(negedge clk);
    check("empty_valid", pixel_valid, 0);
    check("empty_count", fifo_count, 0);
    check("empty_hold_rgb", pixel_rgb, 24'hA00003);
    clear_overflow = 1;
    @(negedge clk); clear_overflow = 0;
    check("ovf_cleared", overflow, 0);

    // drop coinciding with clear: set wins
    pixel_ready = 0;
    for (int i = 0; i < 4; i++) send(px(24'hB00000 + 24'(i)), 1);
    idle();
    repeat (4) @(negedge clk);
    send(px(24'hBFFFFF), 0); idle();
    @(negedge clk);
    @(negedge clk); clear_overflow = 1;
    @(negedge clk); clear_overflow = 0;
    check("set_wins", overflow, 1);
    check("set_wins_count", fifo_count, 4);
    @(negedge clk); clear_overflow = 1;
    @(negedge clk); clear_overflow = 0;
    check("clear_again", overflow, 0);

    // full FIFO with concurrent push and pop: nothing dropped
    for (int i = 0; i < 8; i++) begin
      send(px(24'hC00000 + 24'(i)), 1);
      if (i == 3) begin
        check("full_pre", fifo_count, 4);
        pixel_ready = 1;
      end
      if (i == 5) check("full_stream", fifo_count, 4);
    end
    idle();
    drain(40);
    check("stream_no_drop", overflow, 0);

    // reset with 2 stored and 3 in flight
    pixel_ready = 0;
    send(px(24'hD00000), 0); send(px(24'hD00001), 0); idle();
    repeat (4) @(negedge clk);
    check("pre_rst_count", fifo_count, 2);
    send(px(24'hD00002), 0); send(px(24'hD00003), 0); send(px(24'hD00004), 0);
    @(negedge clk); valid_in = 0;
    #2 rst = 0;
    #1;
    check("mid_rst_valid", pixel_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_rgb", pixel_rgb, 0);
    q.delete();
    @(negedge clk); rst = 1; pixel_ready = 1;
    send(px(24'hE0E0E0), 1); idle();
    check("post_c1", pixel_valid, 0);
    @(negedge clk);
    @(negedge clk); check("post_c3", pixel_valid, 0);
    @(negedge clk); check("post_c4", pixel_valid, 1);
    check("post_rgb", pixel_rgb, 24'hE0E0E0);
    drain(10);
    repeat (6) @(negedge clk);
    check("post_alone_valid", pixel_valid, 0);
    check("post_alone_count", fifo_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
